multimode_shift_reg: RTL and testbench

Parametrised multi-mode shift register generalising the single-bit enabled D flip-flop to a WIDTH-bit register with hold, parallel load, shift left/right and rotate modes. It serves as the common serialiser/deserialiser and register-stage building block for the clocked-circuit exercises. An optional shift counter flags completion of a full-word serialisation.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_counter.sv | 53 +++++
 rtl/multimode_shift_reg.sv | 82 ++++++++
 tb/tb_multimode_shift_reg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-mode shift register.
// Holds the operation-mode encodings and the shift-counter state encoding.
package shift_pkg;

    // Operation select values for i_mode
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    // Shift-counter state: IDLE is disarmed, ARMED counts shifts since a load
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/shift_counter.sv
// Shift counter for the multi-mode shift register.
// A load arms the counter with count 0. Each enabled shift while armed
// increments the count. The shift that reaches WIDTH pulses o_done for one
// cycle and disarms the counter. Only instantiated when SHIFT_CNT_EN is defined.
module shift_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_load,
    input  logic i_shift,
    output logic o_done
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    cnt_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_done;

    // Arm on load, count enabled shifts while armed, pulse done on the WIDTH-th shift
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            // done is a single-cycle pulse and clears regardless of i_en
            r_done <= 1'b0;
            if (i_en) begin
                if (i_load) begin
                    r_state <= ARMED;
                    r_cnt   <= '0;
                end else if (i_shift && (r_state == ARMED)) begin
                    if (r_cnt == LAST) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign o_done = r_done;

endmodule

// File: rtl/multimode_shift_reg.sv
// WIDTH-bit register with hold, parallel load, shift left/right and rotate.
// o_sout holds the bit that left the register on the most recent shift.
// Optional feature macro SHIFT_CNT_EN: when defined, a shift counter flags
// completion of WIDTH shifts since the last load on o_done; otherwise o_done is 0.
module multimode_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_rotate,
    input  logic             i_sin,
    input  logic [WIDTH-1:0] i_pdata,
    output logic [WIDTH-1:0] o_pdata,
    output logic             o_sout,
    output logic             o_done
);

    logic [WIDTH-1:0] r_data;
    logic             r_sout;
    logic             w_in_left;
    logic             w_in_right;

    // Bit entering on a shift: the departing bit when rotating, else serial input
    assign w_in_left  = i_rotate ? r_data[WIDTH-1] : i_sin;
    assign w_in_right = i_rotate ? r_data[0]       : i_sin;

    // Register update; i_en low freezes both the word and the shifted-out bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= RESET_VAL;
            r_sout <= 1'b0;
        end else if (i_en) begin
            case (i_mode)
                MODE_LOAD: begin
                    r_data <= i_pdata;
                end
                MODE_SHL: begin
                    r_data <= {r_data[WIDTH-2:0], w_in_left};
                    r_sout <= r_data[WIDTH-1];
                end
                MODE_SHR: begin
                    r_data <= {w_in_right, r_data[WIDTH-1:1]};
                    r_sout <= r_data[0];
                end
                default: begin
                    r_data <= r_data;
                end
            endcase
        end
    end

    assign o_pdata = r_data;
    assign o_sout  = r_sout;

`ifdef SHIFT_CNT_EN
    logic w_load;
    logic w_shift;

    // Shift modes both have the upper mode bit set
    assign w_load  = (i_mode == MODE_LOAD);
    assign w_shift = i_mode[1];

    shift_counter #(
        .WIDTH (WIDTH)
    ) u_shift_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_load  (w_load),
        .i_shift (w_shift),
        .o_done  (o_done)
    );
`else
    assign o_done = 1'b0;
`endif

endmodule

// File: tb/tb_multimode_shift_reg.sv
// Scoreboard testbench for multimode_shift_reg (WIDTH=8, RESET_VAL=0).
// Stimulus pushes hand-computed expectations; a monitor compares after each edge.
module tb_multimode_shift_reg;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] SHL  = 2'b10;
    localparam logic [1:0] SHR  = 2'b11;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b0;
    logic [1:0] i_mode = HOLD;
    logic       i_rotate = 1'b0;
    logic       i_sin = 1'b0;
    logic [7:0] i_pdata = 8'h00;
    logic [7:0] o_pdata;
    logic       o_sout;
    logic       o_done;

    typedef struct {
        int         id;
        logic [7:0] pdata;
        logic       sout;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    multimode_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_mode   (i_mode),
        .i_rotate (i_rotate),
        .i_sin    (i_sin),
        .i_pdata  (i_pdata),
        .o_pdata  (o_pdata),
        .o_sout   (o_sout),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Without the counter compiled in, o_done must stay 0
    function automatic logic done_exp(input logic d);
`ifdef SHIFT_CNT_EN
        return d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check8(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%02h expected 0x%02h", name, id, act, req);
        end
    endtask

    task automatic check1(input string name, input int id, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %b expected %b", name, id, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs
    task automatic step(input logic en, input logic [1:0] mode, input logic rot, input logic sin,
                        input logic [7:0] pd, input logic [7:0] ep, input logic es, input logic ed);
        exp_t e;
        @(negedge i_clk);
        i_en     = en;
        i_mode   = mode;
        i_rotate = rot;
        i_sin    = sin;
        i_pdata  = pd;
        vec_id++;
        e.id    = vec_id;
        e.pdata = ep;
        e.sout  = es;
        e.done  = done_exp(ed);
        q.push_back(e);
    endtask

    // Assert reset between edges and check outputs clear without an edge
    task automatic async_reset();
        @(negedge i_clk);
        i_en = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        vec_id++;
        check8("rst_pdata", vec_id, o_pdata, 8'h00);
        check1("rst_sout", vec_id, o_sout, 1'b0);
        check1("rst_done", vec_id, o_done, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Monitor: compare every queued expectation just after the edge it applies to
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check8("pdata", e.id, o_pdata, e.pdata);
                check1("sout", e.id, o_sout, e.sout);
                check1("done", e.id, o_done, e.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        @(negedge i_clk);
        @(negedge i_clk);
        vec_id++;
        check8("por_pdata", vec_id, o_pdata, 8'h00);
        check1("por_sout", vec_id, o_sout, 1'b0);
        check1("por_done", vec_id, o_done, 1'b0);
        i_rst = 1'b0;

        // Load and enable gating
        step(1, LOAD, 0, 0, 8'hA5, 8'hA5, 0, 0);
        step(0, LOAD, 0, 0, 8'hFF, 8'hA5, 0, 0);
        step(0, SHL,  0, 1, 8'h00, 8'hA5, 0, 0);
        step(1, HOLD, 0, 1, 8'hFF, 8'hA5, 0, 0);

        // Plain shifts
        step(1, SHL, 0, 1, 8'h00, 8'h4B, 1, 0);
        step(1, SHR, 0, 0, 8'h00, 8'h25, 1, 0);

        // Asynchronous reset with nonzero state
        async_reset();

        // Rotate right through a full word; done on the 8th
        step(1, LOAD, 0, 0, 8'h81, 8'h81, 0, 0);
        step(1, SHR, 1, 0, 8'h00, 8'hC0, 1, 0);
        step(1, SHR, 1, 0, 8'h00, 8'h60, 0, 0);
        step(1, SHR, 1, 0, 8'h00, 8'h30, 0, 0);
        step(1, SHR, 1, 0, 8'h00, 8'h18, 0, 0);
        step(1, SHR, 1, 0, 8'h00, 8'h0C, 0, 0);
        step(1, SHR, 1, 0, 8'h00, 8'h06, 0, 0);
        step(1, SHR, 1, 0, 8'h00, 8'h03, 0, 0);
        step(1, SHR, 1, 0, 8'h00, 8'h81, 1, 1);
        step(1, HOLD, 0, 0, 8'h00, 8'h81, 1, 0);

        // Restart: 5 shifts then reload gives no done
        step(1, LOAD, 0, 0, 8'h0F, 8'h0F, 1, 0);
        step(1, SHL, 0, 0, 8'h00, 8'h1E, 0, 0);
        step(1, SHL, 0, 0, 8'h00, 8'h3C, 0, 0);
        step(1, SHL, 0, 0, 8'h00, 8'h78, 0, 0);
        step(1, SHL, 0, 0, 8'h00, 8'hF0, 0, 0);
        step(1, SHL, 0, 0, 8'h00, 8'hE0, 1, 0);
        step(1, LOAD, 0, 0, 8'h0F, 8'h0F, 1, 0);
        // 8 shifts with a 3-cycle stall: done 11 edges after the reload
        step(1, SHL, 0, 0, 8'h00, 8'h1E, 0, 0);
        step(1, SHL, 0, 0, 8'h00, 8'h3C, 0, 0);
        step(1, SHL, 0, 0, 8'h00, 8'h78, 0, 0);
        step(1, SHL, 0, 0, 8'h00, 8'hF0, 0, 0);
        step(0, SHL, 0, 0, 8'h00, 8'hF0, 0, 0);
        step(0, SHL, 0, 0, 8'h00, 8'hF0, 0, 0);
        step(0, SHL, 0, 0, 8'h00, 8'hF0, 0, 0);
        step(1, SHL, 0, 0, 8'h00, 8'hE0, 1, 0);
        step(1, SHL, 0, 0, 8'h00, 8'hC0, 1, 0);
        step(1, SHL, 0, 0, 8'h00, 8'h80, 1, 0);
        step(1, SHL, 0, 0, 8'h00, 8'h00, 1, 1);
        // done clears on the next edge even with i_en low
        step(0, SHL, 0, 0, 8'h00, 8'h00, 1, 0);

        // Reset mid-count aborts the sequence
        step(1, LOAD, 0, 0, 8'h33, 8'h33, 1, 0);
        step(1, SHR, 0, 1, 8'h00, 8'h99, 1, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hCC, 1, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hE6, 0, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hF3, 0, 0);
        async_reset();
        step(1, SHR, 0, 1, 8'h00, 8'h80, 0, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hC0, 0, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hE0, 0, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hF0, 0, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hF8, 0, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hFC, 0, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hFE, 0, 0);
        step(1, SHR, 0, 1, 8'h00, 8'hFF, 0, 0);

        // Rotate left
        step(1, LOAD, 0, 0, 8'h81, 8'h81, 0, 0);
        step(1, SHL, 1, 0, 8'h00, 8'h03, 1, 0);

        // Drain the scoreboard
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
